// File: rtl/simmem_release_tracker_pkg.sv
// Shared types and constants for the simmem release tracker.
// IDWidth/DelayWidth are the same defaults used by simmem_linkedlist_bank.
// Optional feature macro: SIMMEM_RELEASE_TRACKER_STATS_EN (see top module).
package simmem_release_tracker_pkg;

  localparam int unsigned IDWidth    = 2;
  localparam int unsigned DelayWidth = 8;
  localparam int unsigned NumIds     = 2 ** IDWidth;

  // One tracked request: expired when valid and counter has reached zero.
  typedef struct packed {
    logic                  valid;
    logic [IDWidth-1:0]    id;
    logic [DelayWidth-1:0] counter;
  } slot_t;

  // One-hot release line for a given ID.
  function automatic logic [NumIds-1:0] id_onehot(input logic [IDWidth-1:0] id);
    logic [NumIds-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/simmem_release_tracker_if.sv
// Request / ack / release bundle between the upstream writer, the tracker and
// the linked-list bank. The slave modport is the tracker's view.
// Optional feature macro: SIMMEM_RELEASE_TRACKER_STATS_EN (stats are plain
// ports on the tracker, not part of this bundle).
interface simmem_release_tracker_if;
  import simmem_release_tracker_pkg::*;

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [IDWidth-1:0]    in_id_i;
  logic [DelayWidth-1:0] in_delay_i;
  logic                  ack_valid_i;
  logic [IDWidth-1:0]    ack_id_i;
  logic [NumIds-1:0]     release_en_o;
  logic                  ack_err_o;

  modport slave (
    input  in_valid_i,
    input  in_id_i,
    input  in_delay_i,
    input  ack_valid_i,
    input  ack_id_i,
    output in_ready_o,
    output release_en_o,
    output ack_err_o
  );

  modport master (
    output in_valid_i,
    output in_id_i,
    output in_delay_i,
    output ack_valid_i,
    output ack_id_i,
    input  in_ready_o,
    input  release_en_o,
    input  ack_err_o
  );

endinterface

// File: rtl/simmem_release_tracker_prio_enc.sv
// Find-first-set: index of the lowest set request bit plus a found flag.
module simmem_prio_enc #(
  parameter  int unsigned Width    = 16,
  localparam int unsigned IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    req,
  output logic [IdxWidth-1:0] idx,
  output logic                found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IdxWidth'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simmem_release_tracker.sv
// Per-ID release enable generator for simmem_linkedlist_bank.
// Each accepted request occupies a slot that counts its delay down to zero;
// an expired slot raises release_en for its ID until the bank acks it.
// Optional feature macro: SIMMEM_RELEASE_TRACKER_STATS_EN adds occupancy_o
// and released_cnt_o.
module simmem_release_tracker
  import simmem_release_tracker_pkg::*;
#(
  parameter int unsigned NumSlots = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  simmem_release_tracker_if.slave         bus
`ifdef SIMMEM_RELEASE_TRACKER_STATS_EN
  ,
  output logic [$clog2(NumSlots + 1)-1:0] occupancy_o,
  output logic [31:0]                     released_cnt_o
`endif
);

  localparam int unsigned SlotIdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;

  slot_t                   slot_reg  [NumSlots];
  slot_t                   slot_next [NumSlots];
  logic [NumSlots-1:0]     free_vec;
  logic [NumSlots-1:0]     expired_vec;
  logic [NumSlots-1:0]     ack_match_vec;
  logic [SlotIdxWidth-1:0] free_idx;
  logic [SlotIdxWidth-1:0] ack_idx;
  logic                    free_found;
  logic                    ack_found;
  logic                    accept;
  logic                    ack_ok;
  logic                    ack_err_reg;
  logic                    ack_err_next;
  logic [NumIds-1:0]       release_en;

  // Per-slot status vectors, all derived from registered state only.
  generate
    for (genvar gi = 0; gi < NumSlots; gi++) begin : g_slot_status
      assign free_vec[gi]      = ~slot_reg[gi].valid;
      assign expired_vec[gi]   = slot_reg[gi].valid && (slot_reg[gi].counter == '0);
      assign ack_match_vec[gi] = expired_vec[gi] && (slot_reg[gi].id == bus.ack_id_i);
    end
  endgenerate

  simmem_prio_enc #(.Width(NumSlots)) u_free_sel (
    .req   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  simmem_prio_enc #(.Width(NumSlots)) u_ack_sel (
    .req   (ack_match_vec),
    .idx   (ack_idx),
    .found (ack_found)
  );

  // A slot freed by an ack this edge only shows up as free next cycle, so the
  // accept target can never be the slot being acked.
  assign bus.in_ready_o = free_found;
  assign accept         = bus.in_valid_i && free_found;
  assign ack_ok         = bus.ack_valid_i && ack_found;
  assign ack_err_next   = bus.ack_valid_i && !ack_found;

  // OR together the one-hot ID of every expired slot.
  always_comb begin
    release_en = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (expired_vec[i]) begin
        release_en = release_en | id_onehot(slot_reg[i].id);
      end
    end
  end

  assign bus.release_en_o = release_en;
  assign bus.ack_err_o    = ack_err_reg;

  // Next slot state: countdown, then ack-free, then load of the chosen free slot.
  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      slot_next[i] = slot_reg[i];
      if (slot_reg[i].valid && (slot_reg[i].counter != '0)) begin
        slot_next[i].counter = slot_reg[i].counter - DelayWidth'(1);
      end
      if (ack_ok && (ack_idx == SlotIdxWidth'(i))) begin
        slot_next[i].valid   = 1'b0;
        slot_next[i].counter = '0;
      end
      if (accept && (free_idx == SlotIdxWidth'(i))) begin
        slot_next[i].valid   = 1'b1;
        slot_next[i].id      = bus.in_id_i;
        slot_next[i].counter = bus.in_delay_i;
      end
    end
  end

  // Slot array and error pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) begin
        slot_reg[i] <= '0;
      end
      ack_err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        slot_reg[i] <= slot_next[i];
      end
      ack_err_reg <= ack_err_next;
    end
  end

`ifdef SIMMEM_RELEASE_TRACKER_STATS_EN
  localparam int unsigned OccWidth = $clog2(NumSlots + 1);

  logic [OccWidth-1:0] occupancy_reg;
  logic [31:0]         released_cnt_reg;

  // Valid-slot count and successful-ack total, updated on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occupancy_reg    <= '0;
      released_cnt_reg <= '0;
    end else begin
      occupancy_reg    <= occupancy_reg + OccWidth'(accept) - OccWidth'(ack_ok);
      released_cnt_reg <= released_cnt_reg + 32'(ack_ok);
    end
  end

  assign occupancy_o    = occupancy_reg;
  assign released_cnt_o = released_cnt_reg;
`endif

endmodule

// File: tb/tb_simmem_release_tracker.sv
// Self-checking bench for simmem_release_tracker. A scoreboard records each
// accepted request with the cycle it must become releasable; acks retire
// entries. Stats checks compile only with SIMMEM_RELEASE_TRACKER_STATS_EN.
module tb_simmem_release_tracker;
  import simmem_release_tracker_pkg::*;

  localparam int NS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simmem_release_tracker_if bus ();

`ifdef SIMMEM_RELEASE_TRACKER_STATS_EN
  logic [$clog2(NS + 1)-1:0] occupancy;
  logic [31:0]               released_cnt;
`endif

  simmem_release_tracker #(.NumSlots(NS)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus)
`ifdef SIMMEM_RELEASE_TRACKER_STATS_EN
    ,
    .occupancy_o    (occupancy),
    .released_cnt_o (released_cnt)
`endif
  );

  typedef struct {
    int id;
    int due;
  } ent_t;

  ent_t              sb[$];
  int                cyc;
  int                checks;
  int                errors;
  int                exp_acks;
  int                exp_occ;
  logic [NumIds-1:0] exp_rel;
  logic              exp_err;
  logic              exp_ready;

  // One clock of stimulus; updates the scoreboard with what the edge must do.
  task automatic tick(input logic v, input int id, input int d, input logic av, input int aid);
    bit acc;
    int hit;
    bus.in_valid_i  = v;
    bus.in_id_i     = id[IDWidth-1:0];
    bus.in_delay_i  = d[DelayWidth-1:0];
    bus.ack_valid_i = av;
    bus.ack_id_i    = aid[IDWidth-1:0];
    acc = v && (sb.size() < NS);
    hit = -1;
    foreach (sb[i]) begin
      if (hit < 0 && sb[i].id == aid && sb[i].due <= cyc) hit = i;
    end
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    if (av) begin
      if (hit >= 0) begin
        sb.delete(hit);
        exp_acks++;
      end else begin
        exp_err = 1'b1;
      end
      $display("cyc %0d ack id=%0d hit=%0d", cyc, aid, hit >= 0);
    end
    if (acc) begin
      sb.push_back('{id, cyc + 1 + d});
      $display("cyc %0d accept id=%0d delay=%0d due=%0d", cyc, id, d, cyc + 1 + d);
    end
    cyc++;
    exp_rel = '0;
    foreach (sb[i]) begin
      if (sb[i].due <= cyc) exp_rel[sb[i].id] = 1'b1;
    end
    exp_ready = (sb.size() < NS);
    exp_occ   = sb.size();
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.in_id_i     = '0;
    bus.in_delay_i  = '0;
    bus.ack_valid_i = 1'b0;
    bus.ack_id_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    sb.delete();
    cyc       = 0;
    exp_rel   = '0;
    exp_err   = 1'b0;
    exp_ready = 1'b1;
    exp_occ   = 0;
    exp_acks  = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready_o);
    end
    checks++;
    if (bus.release_en_o !== 4'b0000) begin
      errors++; $display("FAIL reset_release: got %b expected 0000", bus.release_en_o);
    end
    checks++;
    if (bus.ack_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_ack_err: got %b expected 0", bus.ack_err_o);
    end
`ifdef SIMMEM_RELEASE_TRACKER_STATS_EN
    checks++;
    if (occupancy !== 0 || released_cnt !== 0) begin
      errors++; $display("FAIL reset_stats: got occ=%0d cnt=%0d expected 0/0", occupancy, released_cnt);
    end
`endif
  endtask

  task automatic test_basic();
    tick(1'b1, 1, 0, 1'b0, 0);
    checks++;
    if (bus.release_en_o !== 4'b0010) begin
      errors++; $display("FAIL basic_release: got %b expected 0010", bus.release_en_o);
    end
    tick(1'b0, 0, 0, 1'b1, 1);
    checks++;
    if (bus.release_en_o !== 4'b0000) begin
      errors++; $display("FAIL basic_after_ack: got %b expected 0000", bus.release_en_o);
    end
    checks++;
    if (bus.in_ready_o !== 1'b1 || bus.ack_err_o !== 1'b0) begin
      errors++; $display("FAIL basic_ready_err: got ready=%b err=%b expected 1/0",
                         bus.in_ready_o, bus.ack_err_o);
    end
  endtask

  task automatic test_latency();
    do_reset();
    repeat (3) tick(1'b0, 0, 0, 1'b0, 0);
    tick(1'b1, 2, 5, 1'b0, 0);  // accepted at edge 3
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.release_en_o[2] !== (cyc >= 9)) begin
        errors++; $display("FAIL latency_cycle%0d: got %b expected %b", cyc, bus.release_en_o[2], cyc >= 9);
      end
      checks++;
      if (bus.release_en_o !== exp_rel) begin
        errors++; $display("FAIL latency_vec_cycle%0d: got %b expected %b", cyc, bus.release_en_o, exp_rel);
      end
      tick(1'b0, 0, 0, 1'b0, 0);
    end
    tick(1'b0, 0, 0, 1'b1, 2);
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < NS; i++) tick(1'b1, i % 4, 255, 1'b0, 0);
    checks++;
    if (bus.in_ready_o !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b expected 0", bus.in_ready_o);
    end
    // 17th request held while all slots count down.
    for (int k = 0; k < 300 && exp_rel == '0; k++) begin
      tick(1'b1, 3, 7, 1'b0, 0);
      checks++;
      if (bus.in_ready_o !== 1'b0 || bus.release_en_o !== exp_rel) begin
        errors++; $display("FAIL full_wait_cycle%0d: got ready=%b rel=%b expected 0/%b",
                           cyc, bus.in_ready_o, bus.release_en_o, exp_rel);
      end
    end
    checks++;
    if (exp_rel == '0) begin
      errors++; $display("FAIL full_timeout: got no expiry expected expiry by cycle 300");
    end
    // Same-edge ack and held request: ack wins, request waits one cycle.
    tick(1'b1, 3, 7, 1'b1, 0);
    checks++;
    if (bus.in_ready_o !== 1'b1 || bus.release_en_o !== exp_rel) begin
      errors++; $display("FAIL full_same_edge: got ready=%b rel=%b expected 1/%b",
                         bus.in_ready_o, bus.release_en_o, exp_rel);
    end
    tick(1'b1, 3, 7, 1'b0, 0);
    checks++;
    if (bus.in_ready_o !== 1'b0) begin
      errors++; $display("FAIL full_refill: got ready=%b expected 0", bus.in_ready_o);
    end
`ifdef SIMMEM_RELEASE_TRACKER_STATS_EN
    checks++;
    if (occupancy !== 16) begin
      errors++; $display("FAIL full_occupancy: got %0d expected 16", occupancy);
    end
`endif
    // Asynchronous reset mid-countdown clears everything without a clock edge.
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.release_en_o !== 4'b0000 || bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL async_reset: got rel=%b ready=%b expected 0000/1",
                         bus.release_en_o, bus.in_ready_o);
    end
    do_reset();
  endtask

  task automatic test_same_id();
    do_reset();
    tick(1'b1, 0, 2, 1'b0, 0);
    tick(1'b1, 0, 4, 1'b0, 0);
    for (int k = 0; k < 20 && !exp_rel[0]; k++) tick(1'b0, 0, 0, 1'b0, 0);
    checks++;
    if (bus.release_en_o[0] !== 1'b1) begin
      errors++; $display("FAIL same_id_first: got %b expected 1", bus.release_en_o[0]);
    end
    tick(1'b0, 0, 0, 1'b1, 0);
    checks++;
    if (bus.release_en_o[0] !== 1'b0) begin
      errors++; $display("FAIL same_id_gap: got %b expected 0", bus.release_en_o[0]);
    end
    for (int k = 0; k < 20 && !exp_rel[0]; k++) begin
      tick(1'b0, 0, 0, 1'b0, 0);
      checks++;
      if (bus.release_en_o !== exp_rel) begin
        errors++; $display("FAIL same_id_wait_cycle%0d: got %b expected %b", cyc, bus.release_en_o, exp_rel);
      end
    end
    checks++;
    if (bus.release_en_o[0] !== 1'b1 || cyc != 6) begin
      errors++; $display("FAIL same_id_second: got %b at cycle %0d expected 1 at cycle 6",
                         bus.release_en_o[0], cyc);
    end
    tick(1'b0, 0, 0, 1'b1, 0);
    checks++;
    if (bus.release_en_o !== 4'b0000) begin
      errors++; $display("FAIL same_id_done: got %b expected 0000", bus.release_en_o);
    end
`ifdef SIMMEM_RELEASE_TRACKER_STATS_EN
    checks++;
    if (released_cnt !== 32'd2) begin
      errors++; $display("FAIL same_id_count: got %0d expected 2", released_cnt);
    end
`endif
  endtask

  task automatic test_ack_err();
    do_reset();
    tick(1'b1, 3, 50, 1'b0, 0);
    tick(1'b1, 1, 0, 1'b0, 0);
    tick(1'b0, 0, 0, 1'b1, 3);
    checks++;
    if (bus.ack_err_o !== 1'b1) begin
      errors++; $display("FAIL ack_err_pulse: got %b expected 1", bus.ack_err_o);
    end
    tick(1'b0, 0, 0, 1'b0, 0);
    checks++;
    if (bus.ack_err_o !== 1'b0) begin
      errors++; $display("FAIL ack_err_clear: got %b expected 0", bus.ack_err_o);
    end
    checks++;
    if (bus.release_en_o !== 4'b0010) begin
      errors++; $display("FAIL ack_err_slots: got %b expected 0010", bus.release_en_o);
    end
`ifdef SIMMEM_RELEASE_TRACKER_STATS_EN
    checks++;
    if (occupancy !== 2) begin
      errors++; $display("FAIL ack_err_occupancy: got %0d expected 2", occupancy);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      checks++;
      if (bus.release_en_o !== exp_rel || bus.in_ready_o !== exp_ready || bus.ack_err_o !== exp_err) begin
        errors++; $display("FAIL random_cycle%0d: got rel=%b ready=%b err=%b expected %b/%b/%b",
                           cyc, bus.release_en_o, bus.in_ready_o, bus.ack_err_o,
                           exp_rel, exp_ready, exp_err);
      end
`ifdef SIMMEM_RELEASE_TRACKER_STATS_EN
      checks++;
      if (occupancy !== exp_occ[$bits(occupancy)-1:0] || released_cnt !== exp_acks) begin
        errors++; $display("FAIL random_stats_cycle%0d: got occ=%0d cnt=%0d expected %0d/%0d",
                           cyc, occupancy, released_cnt, exp_occ, exp_acks);
      end
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_latency();
    test_full();
    test_same_id();
    test_ack_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
